// File: rtl/scan_ctrl_pkg.sv
// Shared types and helpers for the multi-channel scan-chain controller.
package scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PHI,
    HOLD,
    PHIB,
    LOAD,
    DONE
  } state_t;

  // Cycles from the accepting edge up to and including the done cycle.
  function automatic int unsigned xfer_cycles(input int unsigned nbits,
                                              input int unsigned div);
    return nbits * (2 * div + 2) + div + 1;
  endfunction

endpackage

// File: rtl/scan_phase_gen.sv
// DIV-cycle phase counter; flags the last cycle of a phi, phi_bar or load phase.
module scan_phase_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic last
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0] cnt;

  assign last = (cnt == DW'(DIV - 1));

  // Count while a timed phase is active; restart at the phase boundary or when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             cnt <= '0;
    else if (run && !last)  cnt <= cnt + DW'(1);
    else                    cnt <= '0;
  end

endmodule

// File: rtl/scan_ctrl_mc.sv
// Multi-channel scan-chain controller: two-phase serial write with read-back compare.
module scan_ctrl_mc #(
  parameter  int unsigned NBITS = 64,
  parameter  int unsigned NCHAN = 2,
  parameter  int unsigned DIV   = 2,
  localparam int unsigned CW    = (NCHAN > 1) ? $clog2(NCHAN) : 1,
  localparam int unsigned NW    = $clog2(NBITS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CW-1:0]    chan_sel,
  input  logic [NBITS-1:0] data_in,
  input  logic             scan_data_out,
  output logic             busy,
  output logic             done,
  output logic [NCHAN-1:0] scan_id,
  output logic             scan_phi,
  output logic             scan_phi_bar,
  output logic             scan_data_in,
  output logic             scan_load_chip,
  output logic [NW-1:0]    nbits_cnt,
  output logic [NBITS-1:0] rd_data,
  output logic             match
);

  import scan_ctrl_pkg::*;

  state_t           state, state_nx;
  logic [NBITS-1:0] shadow;
  logic [NBITS-1:0] word;
  logic [CW-1:0]    chan;
  logic [CW-1:0]    sel_nx;
  logic [NBITS-1:0] mirror [NCHAN];
  logic             ph_last;
  logic             ph_run;
  logic             chan_ok;
  logic             accept;
  logic             bit_done;
  logic             load_fin;
  logic             more_bits;
  logic             active_nx;

  assign chan_ok   = ({1'b0, chan_sel} < (CW + 1)'(NCHAN));
  assign accept    = (state == IDLE) && start && !abort && chan_ok;
  assign bit_done  = (state == PHIB) && ph_last && !abort;
  assign load_fin  = (state == LOAD) && ph_last && !abort;
  assign more_bits = (nbits_cnt < NW'(NBITS - 1));
  assign ph_run    = ((state == PHI) || (state == PHIB) || (state == LOAD)) && !abort;
  assign active_nx = (state_nx == SETUP) || (state_nx == PHI) || (state_nx == HOLD) ||
                     (state_nx == PHIB)  || (state_nx == LOAD);
  assign sel_nx    = accept ? chan_sel : chan;

  scan_phase_gen #(.DIV(DIV)) u_phase (
    .clk   (clk),
    .reset (reset),
    .run   (ph_run),
    .last  (ph_last)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = SETUP;
      SETUP:   state_nx = PHI;
      PHI:     if (ph_last) state_nx = HOLD;
      HOLD:    state_nx = PHIB;
      PHIB:    if (ph_last) state_nx = more_bits ? SETUP : LOAD;
      LOAD:    if (ph_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  // Outputs are registered from the next state so each pin is valid for the whole state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      scan_id        <= '0;
      scan_phi       <= 1'b0;
      scan_phi_bar   <= 1'b0;
      scan_data_in   <= 1'b0;
      scan_load_chip <= 1'b0;
      nbits_cnt      <= '0;
      rd_data        <= '0;
      match          <= 1'b0;
      shadow         <= '0;
      word           <= '0;
      chan           <= '0;
      for (int unsigned i = 0; i < NCHAN; i++) mirror[i] <= '0;
    end else begin
      busy           <= active_nx;
      done           <= (state_nx == DONE);
      scan_phi       <= (state_nx == PHI);
      scan_phi_bar   <= (state_nx == PHIB);
      scan_load_chip <= (state_nx == LOAD);
      scan_id        <= active_nx ? (NCHAN'(1) << sel_nx) : '0;
      if (accept) begin
        shadow       <= data_in;
        word         <= data_in;
        chan         <= chan_sel;
        nbits_cnt    <= '0;
        rd_data      <= '0;
        match        <= 1'b0;
        scan_data_in <= data_in[NBITS-1];
      end
      if (bit_done) begin
        rd_data   <= {rd_data[NBITS-2:0], scan_data_out};
        shadow    <= {shadow[NBITS-2:0], 1'b0};
        nbits_cnt <= nbits_cnt + NW'(1);
        // Next bit is presented only when another SETUP follows.
        if (more_bits) scan_data_in <= shadow[NBITS-2];
      end
      if (load_fin) begin
        match        <= (rd_data == mirror[chan]);
        mirror[chan] <= word;
      end
      if (abort && (state != IDLE)) scan_data_in <= 1'b0;
    end
  end

endmodule

// File: doc/scan_ctrl_mc.md
# scan_ctrl_mc

Parametrised multi-channel scan-chain controller. It serially loads an NBITS-wide configuration word into one of NCHAN on-chip scan chains using non-overlapping two-phase clocks (scan_phi / scan_phi_bar), then pulses scan_load_chip. It simultaneously captures the old chain contents shifted out on scan_data_out and checks them against a per-channel mirror of the last word written. It sits between the host register interface (start/data) and the chip scan pins in the main ANC datapath.

## Interface
- NBITS, 64, scan word length in bits (>= 2)
- NCHAN, 2, number of scan chains selectable (>= 1)
- DIV, 2, clk cycles per phi / phi_bar high phase (>= 1)
- CW, $clog2(NCHAN) (min 1), width of chan_sel
- NW, $clog2(NBITS+1), width of nbits_cnt
- clk  in  1  system clock; one clock domain
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- abort  in  1  synchronous abort; returns to IDLE
- chan_sel  in  CW  target chain; latched at start
- data_in  in  NBITS  word to write; latched at start
- scan_data_out  in  1  serial data returned from the selected chain
- busy  out  1  high from the cycle after start is accepted until DONE
- done  out  1  one-cycle completion pulse
- scan_id  out  NCHAN  one-hot chain select; 0 when idle
- scan_phi  out  1  phase-1 scan clock
- scan_phi_bar  out  1  phase-2 scan clock
- scan_data_in  out  1  serial data, MSB first
- scan_load_chip  out  1  parallel-load strobe
- nbits_cnt  out  NW  bits completed in the current transfer
- rd_data  out  NBITS  captured old chain contents; valid with done
- match  out  1  rd_data == mirror[chan]; valid with done, held until next start

## Operation
- States: IDLE, SETUP, PHI, HOLD, PHIB, LOAD, DONE.
- IDLE with start=1 (and abort=0):
  - latch data_in to shadow shift register, chan_sel to chan;
  - clear nbits_cnt and rd_data;
  - go to SETUP.
- SETUP (1 cycle):
  - scan_data_in = shadow[NBITS-1];
  - both phases low.
- PHI (DIV cycles): scan_phi=1.
- HOLD (1 cycle): both phases low.
- PHIB (DIV cycles): scan_phi_bar=1.
- Last PHIB cycle:
  - shift scan_data_out into rd_data LSB;
  - shift shadow left by 1;
  - nbits_cnt += 1.
  - Next state is SETUP if nbits_cnt < NBITS, else LOAD.
- LOAD (DIV cycles):
  - scan_load_chip=1;
  - on the last cycle, mirror[chan] <= latched word.
- DONE (1 cycle):
  - done=1, busy=0;
  - match computed against mirror[chan] before that update;
  - go to IDLE.
- scan_phi and scan_phi_bar are never high in the same cycle.
- Each phase is separated by at least one all-low cycle.
- scan_data_in changes only on entry to SETUP.
- scan_id = 1<<chan for SETUP through LOAD; 0 otherwise.
- start while not IDLE: ignored.
- chan_sel >= NCHAN at start: request ignored; stay IDLE, no done.
- abort in any non-IDLE state:
  - next cycle IDLE;
  - all scan outputs 0, busy=0;
  - no done, no mirror update;
  - rd_data / nbits_cnt hold their partial values.
- abort and start in the same IDLE cycle: abort wins.
- Reset values: all outputs 0; mirrors 0; state IDLE.
- Reset asserted mid-transfer: outputs drop asynchronously; the mirror is not updated.

## Timing
- Start accepted on clock edge 0; SETUP occupies cycle 1.
- Bit cost: 2*DIV+2 cycles.
- done high in cycle NBITS*(2*DIV+2)+DIV+1. Defaults: 64*6+2+1 = 387.
- busy high in cycles 1 .. done-1.
- A new start is accepted in the cycle after done (back-to-back allowed).
- scan_data_out is sampled in the last PHIB cycle of each bit. rd_data[0] holds the last bit shifted out.
- All outputs are registered.

## Structure
- Package scan_ctrl_pkg holds:
  - state enum;
  - helper function computing the transfer length in cycles from NBITS/DIV.
- Sub-module scan_phase_gen holds the DIV phase counter and emits phase-last strobes. The main FSM consumes those strobes.
- Mirrors are an NCHAN x NBITS register array inside the top module.

## Test plan
- Bench chip model: NCHAN master-slave shift registers clocked by phi/phi_bar, gated by scan_id, load on scan_load_chip.
- NBITS=64, DIV=2, chan 0, data 64'h02AAAAAAAAAAAAAA:
  - done at cycle 387;
  - model chain 0 holds the word;
  - rd_data=0, match=1.
- Repeat with chan 0, data 64'h123456789ABCDEF0:
  - rd_data=64'h02AAAAAAAAAAAAAA, match=1;
  - then write chan 1 → rd_data=0, match=1.
- Corrupt model chain 1 between writes → match=0 on the next chan-1 write.
- Assertion check, whole run: phi & phi_bar never both 1; each phase exactly DIV cycles; scan_data_in stable outside SETUP.
- abort at nbits_cnt=10:
  - IDLE next cycle, no done, no load pulse;
  - the next full transfer completes normally.
- start during busy, and chan_sel=2 with NCHAN=2 → both ignored.
- reset low mid-transfer → outputs 0 immediately.
- NBITS=8, DIV=1: done at cycle 8*4+2 = 34.
